// File: rtl/i2c_master_contr.sv
// i2c_master_contr
// Single-transaction I2C-style bus master: START, 13-bit header (rw, mem_addr,
// dev_addr, each field LSB first), header ACK, one data byte (LSB first),
// data ACK / master NACK, STOP. SCL is push-pull; SDA is open-drain.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus released, waiting for start
// START  | sda low while scl high for one half-period
// HDR    | 13 header slots driven by master
// HACK   | header acknowledge slot, sda released and sampled
// WR     | 8 data slots driven by master
// DACK   | data acknowledge slot, sda released and sampled
// RD     | 8 data slots driven by slave, sampled into shift register
// NACK   | master NACK slot after a read, sda released
// STOP   | three half-periods: (scl0,sda0) (scl1,sda0) (scl1,released)
module i2c_master_contr #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [4:0] mem_addr,
  input  logic [7:0] wdata,
  output logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_HDR,
    S_HACK,
    S_WR,
    S_DACK,
    S_RD,
    S_NACK,
    S_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic       half_q, half_d;
  logic [3:0] bit_q, bit_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [4:0] mem_q, mem_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;

  logic        sda_in;
  logic        half_end;
  logic        slot_end;
  logic [12:0] hdr_bits;

  assign sda_in   = sda;
  assign half_end = (div_q == DIV_LAST);
  assign slot_end = half_end & half_q;

  // Next-state, counters, status, and the registered bus outputs that follow
  // from the next state (so scl/sda change together with the state).
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    mem_d     = mem_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    if (state_q != S_IDLE) begin
      div_d = half_end ? 8'd0 : div_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        div_d  = 8'd0;
        half_d = 1'b0;
        bit_d  = 4'd0;
        if (start) begin
          rw_d      = rw;
          dev_d     = dev_addr;
          mem_d     = mem_addr;
          wdata_d   = wdata;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (half_end) begin
          state_d = S_HDR;
          half_d  = 1'b0;
          bit_d   = 4'd0;
        end
      end

      S_HDR: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          if (bit_q == 4'd12) begin
            state_d = S_HACK;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      S_HACK: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          bit_d = 4'd0;
          if (sda_in) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            state_d = rw_q ? S_WR : S_RD;
          end
        end
      end

      S_WR: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          if (bit_q == 4'd7) begin
            state_d = S_DACK;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      S_DACK: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          ack_err_d = ack_err_q | sda_in;
          state_d   = S_STOP;
          bit_d     = 4'd0;
        end
      end

      S_RD: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          shift_d = {sda_in, shift_q[7:1]};
          if (bit_q == 4'd7) begin
            rdata_d = {sda_in, shift_q[7:1]};
            state_d = S_NACK;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      S_NACK: begin
        if (half_end) half_d = ~half_q;
        if (slot_end) begin
          state_d = S_STOP;
          bit_d   = 4'd0;
        end
      end

      S_STOP: begin
        // bit counter doubles as the STOP phase index
        if (half_end) begin
          if (bit_q == 4'd2) begin
            state_d = S_IDLE;
            bit_d   = 4'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    hdr_bits = {dev_d, mem_d, rw_d};
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state_d)
      S_START: sda_oe_d = 1'b1;
      S_HDR: begin
        scl_d    = half_d;
        sda_oe_d = ~hdr_bits[bit_d];
      end
      S_WR: begin
        scl_d    = half_d;
        sda_oe_d = ~wdata_d[bit_d[2:0]];
      end
      S_HACK, S_DACK, S_RD, S_NACK: scl_d = half_d;
      S_STOP: begin
        scl_d    = (bit_d != 4'd0);
        sda_oe_d = (bit_d != 4'd2);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns the bus to idle on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      half_q    <= 1'b0;
      bit_q     <= 4'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      mem_q     <= 5'd0;
      wdata_q   <= 8'd0;
      shift_q   <= 8'd0;
      rdata_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      mem_q     <= mem_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign scl     = scl_q;
  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_contr.sv
// Testbench for i2c_master_contr: two instances (CLK_DIV=4 and CLK_DIV=2),
// each with its own open-drain bus, slave model and done-driven monitor.
module tb_i2c_master_contr;

  localparam int CD0 = 4;
  localparam int CD1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic       start_i [2];
  logic       rw_i    [2];
  logic [6:0] dev_i   [2];
  logic [4:0] mem_i   [2];
  logic [7:0] wdata_i [2];
  logic       scl_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       ackerr_o[2];
  logic [7:0] rdata_o [2];
  logic       sda_o   [2];

  logic       slv_hack[2];
  logic       slv_dack[2];
  logic [7:0] slv_data[2];

  // Expected bus picture of one transfer: value seen on sda at every scl rise
  // (header, ack, data, ack/nack, then the STOP rise with sda low).
  typedef struct {
    int          n;
    logic [31:0] bits;
    logic        ack_err;
    logic [7:0]  rdata;
    int          lat;
  } exp_t;

  exp_t       exp_q[2][$];
  int         acc_q[2][$];
  logic [7:0] model_rdata[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic exp_t model(input int cd, input logic rw, input logic [6:0] dev,
                                 input logic [4:0] mem, input logic [7:0] wd,
                                 input logic hack, input logic dack, input logic [7:0] sd,
                                 input logic [7:0] prev);
    exp_t e;
    e.bits = '0;
    e.bits[0] = rw;
    for (int i = 0; i < 5; i++) e.bits[1 + i] = mem[i];
    for (int i = 0; i < 7; i++) e.bits[6 + i] = dev[i];
    e.bits[13] = !hack;
    if (!hack) begin
      e.bits[14] = 1'b0;
      e.n        = 15;
      e.ack_err  = 1'b1;
      e.rdata    = prev;
      e.lat      = 32 * cd;
    end else begin
      for (int i = 0; i < 8; i++) e.bits[14 + i] = rw ? wd[i] : sd[i];
      e.bits[22] = rw ? !dack : 1'b1;
      e.bits[23] = 1'b0;
      e.n        = 24;
      e.ack_err  = rw && !dack;
      e.rdata    = rw ? prev : sd;
      e.lat      = 50 * cd;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int CD = (g == 0) ? CD0 : CD1;
    wire  sda_w;
    logic drv = 1'b0;
    pullup (sda_w);
    assign sda_w    = drv ? 1'b0 : 1'bz;
    assign sda_o[g] = sda_w;

    i2c_master_contr #(.CLK_DIV(CD)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_i[g]),
      .rw      (rw_i[g]),
      .dev_addr(dev_i[g]),
      .mem_addr(mem_i[g]),
      .wdata   (wdata_i[g]),
      .scl     (scl_o[g]),
      .sda     (sda_w),
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .ack_err (ackerr_o[g]),
      .rdata   (rdata_o[g])
    );

    logic        scl_p = 1'b1, sda_p = 1'b1, stop_seen = 1'b0, acc_pend = 1'b0, done_p = 1'b0;
    int          slot = 0;
    logic [31:0] cap = '0;

    // Slave model plus monitor: bus sampled on the falling clk edge.
    always @(negedge clk) begin
      exp_t        e;
      int          a;
      logic [31:0] mask;
      if (acc_pend) begin
        check($sformatf("busy_after_accept_g%0d", g), busy_o[g], 1'b1);
        check($sformatf("ack_err_cleared_g%0d", g), ackerr_o[g], 1'b0);
      end
      acc_pend = 1'b0;
      if (!rst) begin
        drv       = 1'b0;
        slot      = 0;
        stop_seen = 1'b0;
        done_p    = 1'b0;
      end else begin
        if (done_p) check($sformatf("done_one_cycle_g%0d", g), done_o[g], 1'b0);
        if (scl_p && scl_o[g] && sda_p && !sda_w) begin
          slot = 0; cap = '0; stop_seen = 1'b0;
        end
        if (scl_p && scl_o[g] && !sda_p && sda_w) stop_seen = 1'b1;
        if (!scl_p && scl_o[g]) begin
          if (slot < 32) cap[slot] = sda_w;
          slot++;
        end
        if (scl_p && !scl_o[g]) begin
          drv = 1'b0;
          if (slot == 13) drv = slv_hack[g];
          else if (slot >= 14 && slot <= 21 && !cap[0] && slv_hack[g]) drv = !slv_data[g][slot - 14];
          else if (slot == 22 && cap[0] && slv_hack[g]) drv = slv_dack[g];
        end
        if (done_o[g]) begin
          if (exp_q[g].size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done_g%0d: done pulse with no transfer outstanding (cycle %0d)", g, cyc);
          end else begin
            e = exp_q[g].pop_front();
            a = (acc_q[g].size() != 0) ? acc_q[g].pop_front() : -100000;
            mask = (32'd1 << e.n) - 32'd1;
            check($sformatf("latency_g%0d", g), cyc - a, e.lat);
            check($sformatf("ack_err_g%0d", g), ackerr_o[g], e.ack_err);
            check($sformatf("rdata_g%0d", g), rdata_o[g], e.rdata);
            check($sformatf("busy_at_done_g%0d", g), busy_o[g], 1'b0);
            check($sformatf("slot_count_g%0d", g), slot, e.n);
            check($sformatf("frame_bits_g%0d", g), cap & mask, e.bits);
            check($sformatf("stop_seen_g%0d", g), stop_seen, 1'b1);
          end
        end
        if (start_i[g] && !busy_o[g]) begin
          acc_q[g].push_back(cyc + 1);
          acc_pend = 1'b1;
        end
        done_p = done_o[g];
      end
      scl_p = scl_o[g];
      sda_p = sda_w;
    end
  end

  // Called just after a rising edge with the instance idle; acceptance is the next edge.
  task automatic issue(input int g, input logic rw, input logic [6:0] dev, input logic [4:0] mem,
                       input logic [7:0] wd, input logic hack, input logic dack,
                       input logic [7:0] sd, input logic hold, output int acc);
    exp_t e;
    rw_i[g] = rw; dev_i[g] = dev; mem_i[g] = mem; wdata_i[g] = wd;
    slv_hack[g] = hack; slv_dack[g] = dack; slv_data[g] = sd;
    e = model((g == 0) ? CD0 : CD1, rw, dev, mem, wd, hack, dack, sd, model_rdata[g]);
    exp_q[g].push_back(e);
    model_rdata[g] = e.rdata;
    start_i[g] = 1'b1;
    acc = cyc + 1;
    if (!hold) begin
      @(posedge clk); #1;
      start_i[g] = 1'b0;
    end
  endtask

  task automatic wait_done(input int g);
    int t = 0;
    while (exp_q[g].size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q[g].size() != 0) begin
      n_total++;
      $display("FAIL timeout_g%0d: %0d transfers pending after %0d cycles", g, exp_q[g].size(), t);
      exp_q[g].delete();
      acc_q[g].delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic random_txn(input int g);
    int a;
    issue(g, 1'($urandom), 7'($urandom), 5'($urandom), 8'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 8'($urandom), 1'b0, a);
    wait_done(g);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int d[3];
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; rw_i[i] = 1'b0; dev_i[i] = '0; mem_i[i] = '0; wdata_i[i] = '0;
      slv_hack[i] = 1'b0; slv_dack[i] = 1'b0; slv_data[i] = '0; model_rdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_scl_g%0d", i), scl_o[i], 1'b1);
      check($sformatf("reset_sda_g%0d", i), sda_o[i], 1'b1);
      check($sformatf("reset_busy_g%0d", i), busy_o[i], 1'b0);
      check($sformatf("reset_done_g%0d", i), done_o[i], 1'b0);
      check($sformatf("reset_ack_err_g%0d", i), ackerr_o[i], 1'b0);
      check($sformatf("reset_rdata_g%0d", i), rdata_o[i], 8'h00);
    end
    @(posedge clk); #1;

    // directed write, read, header NACK
    issue(0, 1'b1, 7'h2A, 5'h13, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, a);
    wait_done(0);
    issue(0, 1'b0, 7'h05, 5'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, a);
    wait_done(0);
    issue(0, 1'b0, 7'h51, 5'h0A, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, a);
    wait_done(0);

    // start pulse with different inputs during the header must be ignored
    issue(0, 1'b1, 7'h33, 5'h1C, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, a);
    while (cyc < a + 20) begin @(posedge clk); #1; end
    rw_i[0] = 1'b0; dev_i[0] = 7'h4C; mem_i[0] = 5'h03; wdata_i[0] = 8'hF0;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    wait_done(0);
    repeat (250) @(negedge clk);
    @(posedge clk); #1;

    // one-cycle reset in the low half of WR bit 3
    issue(0, 1'b1, 7'h12, 5'h07, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, a);
    while (cyc < a + 35 * CD0) begin @(posedge clk); #1; end
    @(negedge clk);
    check("scl_low_before_reset", scl_o[0], 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete(); acc_q[i].delete(); model_rdata[i] = '0;
    end
    @(negedge clk);
    check("post_reset_scl", scl_o[0], 1'b1);
    check("post_reset_sda", sda_o[0], 1'b1);
    check("post_reset_busy", busy_o[0], 1'b0);
    check("post_reset_done", done_o[0], 1'b0);
    @(posedge clk); #1;
    issue(0, 1'b1, 7'h12, 5'h07, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, a);
    wait_done(0);

    for (int i = 0; i < 6; i++) random_txn(0);
    for (int i = 0; i < 6; i++) random_txn(1);

    // start held high on the CLK_DIV=2 instance: three back-to-back transfers
    issue(1, 1'($urandom), 7'($urandom), 5'($urandom), 8'($urandom),
          1'b1, 1'b1, 8'($urandom), 1'b1, a);
    for (int k = 0; k < 3; k++) begin
      int t = 0;
      d[k] = -1;
      while (t < 400) begin
        @(negedge clk);
        t++;
        if (done_o[1]) begin
          d[k] = cyc;
          break;
        end
      end
      if (d[k] < 0) begin
        n_total++;
        $display("FAIL b2b_timeout: no done for transfer %0d within %0d cycles", k, t);
      end
      if (k < 2) begin
        exp_t e;
        rw_i[1] = 1'($urandom); dev_i[1] = 7'($urandom); mem_i[1] = 5'($urandom);
        wdata_i[1] = 8'($urandom); slv_hack[1] = 1'b1; slv_dack[1] = 1'b1;
        slv_data[1] = 8'($urandom);
        e = model(CD1, rw_i[1], dev_i[1], mem_i[1], wdata_i[1], 1'b1, 1'b1, slv_data[1], model_rdata[1]);
        exp_q[1].push_back(e);
        model_rdata[1] = e.rdata;
      end else begin
        start_i[1] = 1'b0;
      end
    end
    check("b2b_spacing_1", d[1] - d[0], 101);
    check("b2b_spacing_2", d[2] - d[1], 101);
    wait_done(1);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
